// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, arbiter FSM states and an alignment helper.
// No logic of its own; imported by the arbiter, its picker and the bench.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Data access, privileged, non-bufferable, non-cacheable.
  localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

  // Sizes above a word are not issued, so they are reported as misaligned.
  function automatic logic addr_aligned(input logic [1:0] lsb, input logic [2:0] size);
    case (size)
      HSIZE_BYTE: addr_aligned = 1'b1;
      HSIZE_HALF: addr_aligned = ~lsb[0];
      HSIZE_WORD: addr_aligned = (lsb == 2'b00);
      default:    addr_aligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_req_arbiter_if.sv
// Requester-side handshake plus AHB-Lite master bus of the request arbiter.
// master = arbiter view, slave = requesters + AHB slave view.
interface ahb_req_arbiter_if #(
  parameter int NREQ = 2,
  parameter int AW   = 32,
  parameter int DW   = 32
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*3-1:0]  req_size;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic               err;
  logic [DW-1:0]      rdata;

  logic               hsel;
  logic [AW-1:0]      haddr;
  logic [1:0]         htrans;
  logic               hwrite;
  logic [2:0]         hsize;
  logic [2:0]         hburst;
  logic [3:0]         hprot;
  logic [DW-1:0]      hwdata;
  logic [DW-1:0]      hrdata;
  logic               hready;
  logic               hresp;

  modport master (
    input  req, req_we, req_addr, req_size, req_wdata, hrdata, hready, hresp,
    output gnt, done, err, rdata,
           hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata
  );

  modport slave (
    output req, req_we, req_addr, req_size, req_wdata, hrdata, hready, hresp,
    input  gnt, done, err, rdata,
           hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata
  );
endinterface

// File: rtl/ahb_rr_pick.sv
// Combinational one-hot winner: first set req bit searching upward from ptr_i, wrapping.
// Zero latency; an empty req vector yields an all-zero winner.
module ahb_rr_pick #(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] win_o
);

  logic found;

  always_comb begin
    win_o = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!found && req_i[j] && (j == ((int'(ptr_i) + k) % NREQ))) begin
          win_o[j] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ahb_req_arbiter.sv
// N-requester single-transfer AHB-Lite master; done 3 cycles after req with zero waits, +1 per hready=0.
// Requests wait while a transfer is in flight; AHB_ARB_ROUND_ROBIN_EN selects round-robin over fixed priority.
module ahb_req_arbiter
  import ahb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = 32,
  parameter int DW   = 32
) (
  input logic              hclk,
  input logic              hresetn,
  ahb_req_arbiter_if.master bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d, done_q, done_d, win;
  logic            err_q, err_d, we_q, we_d, bad_q, bad_d;
  logic [DW-1:0]   rdata_q, rdata_d, wdata_q, wdata_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [2:0]      size_q, size_d;
  logic [PW-1:0]   ptr_q, ptr_d;

  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [2:0]      sel_size;
  logic [DW-1:0]   sel_wdata;
  logic            addr_phase;

  ahb_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req_i (bus.req),
    .ptr_i (ptr_q),
    .win_o (win)
  );

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_size  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win[i]) begin
        sel_we    = bus.req_we[i];
        sel_addr  = bus.req_addr[i*AW +: AW];
        sel_size  = bus.req_size[i*3 +: 3];
        sel_wdata = bus.req_wdata[i*DW +: DW];
      end
    end
  end

`ifdef AHB_ARB_ROUND_ROBIN_EN
  logic [PW-1:0] sel_idx;

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win[i]) sel_idx = PW'(i);
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    err_d   = err_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    addr_d  = addr_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    bad_d   = bad_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if ((|bus.req) && (gnt_q == '0)) begin
          gnt_d   = win;
          we_d    = sel_we;
          addr_d  = sel_addr;
          size_d  = sel_size;
          wdata_d = sel_wdata;
          bad_d   = ~addr_aligned(sel_addr[1:0], sel_size);
`ifdef AHB_ARB_ROUND_ROBIN_EN
          ptr_d   = (sel_idx == PW'(NREQ - 1)) ? '0 : sel_idx + 1'b1;
`endif
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        // Misaligned requests never reach the bus; they retire here with an error.
        if (bad_q) begin
          done_d  = gnt_q;
          gnt_d   = '0;
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = ST_IDLE;
        end else if (bus.hready) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bus.hready) begin
          done_d  = gnt_q;
          gnt_d   = '0;
          err_d   = bus.hresp;
          rdata_d = we_q ? '0 : bus.hrdata;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      bad_q   <= 1'b0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      bad_q   <= bad_d;
      ptr_q   <= ptr_d;
    end
  end

  assign addr_phase = (state_q == ST_ADDR) && !bad_q;

  assign bus.gnt    = gnt_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.rdata  = rdata_q;
  assign bus.hsel   = addr_phase;
  assign bus.htrans = addr_phase ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.haddr  = addr_phase ? addr_q : '0;
  assign bus.hwrite = addr_phase & we_q;
  assign bus.hsize  = addr_phase ? size_q : HSIZE_BYTE;
  assign bus.hburst = HBURST_SINGLE;
  assign bus.hprot  = HPROT_DATA_PRIV;
  assign bus.hwdata = ((state_q == ST_DATA) && we_q) ? wdata_q : '0;

endmodule

// File: tb/tb_ahb_req_arbiter.sv
// Directed bench for ahb_req_arbiter: reset, arbitration, write/read, waits, ERROR, misalignment, mid-transfer reset.
module tb_ahb_req_arbiter;
  import ahb_pkg::*;

  localparam int NREQ = 2;
  localparam int AW   = 32;
  localparam int DW   = 32;

  logic hclk = 1'b0;
  logic hresetn;
  int   n_chk  = 0;
  int   n_pass = 0;
  logic [1:0]    exp_gnt [4];
  logic [DW-1:0] mem_word;

  ahb_req_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  ahb_req_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .hclk    (hclk),
    .hresetn (hresetn),
    .bus     (bus)
  );

  always #5 hclk = ~hclk;

  task automatic tick;
    @(posedge hclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_req(input int i, input logic we, input logic [31:0] addr,
                         input logic [2:0] size, input logic [31:0] wdata);
    if (i == 0) begin
      bus.req_we[0]         = we;
      bus.req_addr[31:0]    = addr;
      bus.req_size[2:0]     = size;
      bus.req_wdata[31:0]   = wdata;
    end else begin
      bus.req_we[1]         = we;
      bus.req_addr[63:32]   = addr;
      bus.req_size[5:3]     = size;
      bus.req_wdata[63:32]  = wdata;
    end
  endtask

  initial begin
    hresetn       = 1'b0;
    bus.req       = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_size  = '0;
    bus.req_wdata = '0;
    bus.hrdata    = '0;
    bus.hready    = 1'b1;
    bus.hresp     = 1'b0;
    mem_word      = 32'hA5A5_0001;
    tick();
    tick();

    chk("rst_gnt",    64'(bus.gnt),    64'h0);
    chk("rst_done",   64'(bus.done),   64'h0);
    chk("rst_err",    64'(bus.err),    64'h0);
    chk("rst_hsel",   64'(bus.hsel),   64'h0);
    chk("rst_htrans", 64'(bus.htrans), 64'h0);
    chk("rst_haddr",  64'(bus.haddr),  64'h0);
    chk("rst_hwdata", 64'(bus.hwdata), 64'h0);
    hresetn = 1'b1;
    tick();

    // Both requesters held continuously.
    set_req(0, 1'b0, 32'h20, 3'd2, 32'h0);
    set_req(1, 1'b0, 32'h40, 3'd2, 32'h0);
    bus.req = 2'b11;
`ifdef AHB_ARB_ROUND_ROBIN_EN
    exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_gnt = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("arb_gnt",   64'(bus.gnt),   64'(exp_gnt[k]));
      chk("arb_haddr", 64'(bus.haddr), exp_gnt[k][1] ? 64'h40 : 64'h20);
      tick();
      tick();
      chk("arb_done",  64'(bus.done),  64'(exp_gnt[k]));
      if (k == 3) bus.req = 2'b00;
    end

    // Zero-wait write of 0xA5A5_0001 to 0x10.
    set_req(0, 1'b1, 32'h10, 3'd2, 32'hA5A5_0001);
    bus.req = 2'b01;
    tick();
    chk("wr_gnt",    64'(bus.gnt),    64'h1);
    chk("wr_hsel",   64'(bus.hsel),   64'h1);
    chk("wr_htrans", 64'(bus.htrans), 64'(HTRANS_NONSEQ));
    chk("wr_haddr",  64'(bus.haddr),  64'h10);
    chk("wr_hwrite", 64'(bus.hwrite), 64'h1);
    chk("wr_hsize",  64'(bus.hsize),  64'h2);
    chk("wr_hburst", 64'(bus.hburst), 64'h0);
    chk("wr_hprot",  64'(bus.hprot),  64'h3);
    set_req(0, 1'b1, 32'h0, 3'd2, 32'hDEAD_BEEF);
    tick();
    chk("wr_dph_htrans", 64'(bus.htrans), 64'(HTRANS_IDLE));
    chk("wr_dph_hsel",   64'(bus.hsel),   64'h0);
    chk("wr_hwdata",     64'(bus.hwdata), 64'hA5A5_0001);
    chk("wr_no_done",    64'(bus.done),   64'h0);
    tick();
    chk("wr_done",   64'(bus.done), 64'h1);
    chk("wr_err",    64'(bus.err),  64'h0);
    chk("wr_gnt_off", 64'(bus.gnt), 64'h0);
    bus.req = 2'b00;

    // Read back with two wait states in the address phase.
    set_req(0, 1'b0, 32'h10, 3'd2, 32'h0);
    bus.req    = 2'b01;
    bus.hready = 1'b0;
    tick();
    chk("rd_haddr_w1", 64'(bus.haddr),  64'h10);
    chk("rd_htrans_w1", 64'(bus.htrans), 64'(HTRANS_NONSEQ));
    tick();
    chk("rd_haddr_w2", 64'(bus.haddr),  64'h10);
    bus.req = 2'b00;
    tick();
    chk("rd_haddr_w3", 64'(bus.haddr),  64'h10);
    bus.hready = 1'b1;
    tick();
    chk("rd_hwdata0",  64'(bus.hwdata), 64'h0);
    chk("rd_no_done",  64'(bus.done),   64'h0);
    bus.hrdata = mem_word;
    tick();
    chk("rd_done",  64'(bus.done),  64'h1);
    chk("rd_rdata", 64'(bus.rdata), 64'hA5A5_0001);
    chk("rd_err",   64'(bus.err),   64'h0);
    bus.hrdata = '0;

    // Two-cycle ERROR response on a requester-1 write.
    set_req(1, 1'b1, 32'h44, 3'd2, 32'h1234);
    bus.req = 2'b10;
    tick();
    chk("er_gnt",   64'(bus.gnt),   64'h2);
    chk("er_haddr", 64'(bus.haddr), 64'h44);
    tick();
    chk("er_hwdata", 64'(bus.hwdata), 64'h1234);
    bus.hresp  = 1'b1;
    bus.hready = 1'b0;
    tick();
    chk("er_hold_done", 64'(bus.done), 64'h0);
    chk("er_hold_hsel", 64'(bus.hsel), 64'h0);
    bus.hready = 1'b1;
    tick();
    chk("er_done", 64'(bus.done), 64'h2);
    chk("er_err",  64'(bus.err),  64'h1);
    bus.hresp = 1'b0;
    bus.req   = 2'b00;

    // Next transfer after the error completes normally.
    set_req(0, 1'b0, 32'h10, 3'd2, 32'h0);
    bus.req = 2'b01;
    tick();
    chk("nx_htrans", 64'(bus.htrans), 64'(HTRANS_NONSEQ));
    tick();
    bus.hrdata = 32'h5A;
    tick();
    chk("nx_done",  64'(bus.done),  64'h1);
    chk("nx_err",   64'(bus.err),   64'h0);
    chk("nx_rdata", 64'(bus.rdata), 64'h5A);
    bus.req    = 2'b00;
    bus.hrdata = '0;

    // Misaligned word access never reaches the bus.
    set_req(0, 1'b0, 32'h3, 3'd2, 32'h0);
    bus.req = 2'b01;
    tick();
    chk("mis_gnt",    64'(bus.gnt),    64'h1);
    chk("mis_htrans", 64'(bus.htrans), 64'(HTRANS_IDLE));
    chk("mis_hsel",   64'(bus.hsel),   64'h0);
    chk("mis_early",  64'(bus.done),   64'h0);
    tick();
    chk("mis_done",   64'(bus.done),   64'h1);
    chk("mis_err",    64'(bus.err),    64'h1);
    chk("mis_gnt_off", 64'(bus.gnt),   64'h0);

    // Reset asserted while a write sits in its data phase.
    set_req(0, 1'b1, 32'h8, 3'd2, 32'h77);
    bus.req = 2'b01;
    tick();
    tick();
    bus.hready = 1'b0;
    chk("mr_pre_hwdata", 64'(bus.hwdata), 64'h77);
    chk("mr_pre_gnt",    64'(bus.gnt),    64'h1);
    hresetn = 1'b0;
    #1;
    chk("mr_gnt",    64'(bus.gnt),    64'h0);
    chk("mr_done",   64'(bus.done),   64'h0);
    chk("mr_err",    64'(bus.err),    64'h0);
    chk("mr_rdata",  64'(bus.rdata),  64'h0);
    chk("mr_hsel",   64'(bus.hsel),   64'h0);
    chk("mr_htrans", 64'(bus.htrans), 64'h0);
    chk("mr_haddr",  64'(bus.haddr),  64'h0);
    chk("mr_hwdata", 64'(bus.hwdata), 64'h0);
    bus.req    = 2'b00;
    bus.hready = 1'b1;
    tick();
    hresetn = 1'b1;
    tick();
    chk("mr_no_done1", 64'(bus.done), 64'h0);
    tick();
    chk("mr_no_done2", 64'(bus.done), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ahb_req_arbiter.md
AHB_REQ_ARBITER -- requirements
Module: ahb_req_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 2: number of requesters (2..8).
REQ-002 SHALL have parameter AW, default 32: address width.
REQ-003 SHALL have parameter DW, default 32: data width.
REQ-004 SHALL have port hclk  input  1: bus clock.
REQ-005 SHALL have port hresetn  input  1: reset, asynchronous, active-low.
REQ-006 SHALL have port req  input  NREQ: per-requester transfer request, held until done.
REQ-007 SHALL have port req_we  input  NREQ: 1 = write.
REQ-008 SHALL have port req_addr  input  NREQ*AW: byte address.
REQ-009 SHALL have port req_size  input  NREQ*3: HSIZE encoding, 0..2 only.
REQ-010 SHALL have port req_wdata  input  NREQ*DW: write data.
REQ-011 SHALL have port gnt  output  NREQ: one-hot, high from the address phase until done.
REQ-012 SHALL have port done  output  NREQ: one-cycle pulse at transfer completion.
REQ-013 SHALL have port err  output  1: ERROR qualifier, valid with done.
REQ-014 SHALL have port rdata  output  DW: read data, valid with done.
REQ-015 SHALL have ports hsel 1, haddr AW, htrans 2, hwrite 1, hsize 3, hburst 3, hprot 4, hwdata DW  output: AHB-Lite master side.
REQ-016 SHALL have ports hrdata DW, hready 1, hresp 1  input: slave response.

Function
REQ-017 SHALL issue single transfers only: hburst=SINGLE (3'b000), hprot=4'b0011, htrans NONSEQ or IDLE, never SEQ or BUSY.
REQ-018 SHALL implement FSM IDLE -> ADDR -> DATA -> IDLE.
REQ-019 In IDLE with any req bit set and no grant held, SHALL select a winner, latch its we/addr/size/wdata, set gnt, and go to ADDR.
REQ-020 In ADDR SHALL drive hsel=1, htrans=NONSEQ and the latched haddr/hwrite/hsize, holding them until a cycle with hready=1, then go to DATA.
REQ-021 In DATA SHALL drive htrans=IDLE and hsel=0, and drive hwdata with the latched wdata for writes; otherwise hwdata=0.
REQ-022 In DATA, on hready=1, SHALL pulse done[winner], register err=hresp and rdata=hrdata (read only, else 0), drop gnt, and return to IDLE.
REQ-023 On a two-cycle ERROR (hresp=1, hready=0 then hresp=1, hready=1), SHALL hold DATA through the first cycle and complete with err=1 on the second.
REQ-024 Transfer latency with zero wait states: 3 cycles from req sampled to done pulse; each slave wait state adds one cycle.
REQ-025 Requests arriving during ADDR/DATA SHALL wait; the winner's inputs SHALL be ignored after latching.
REQ-026 A req deasserted while its transfer is in flight SHALL NOT abort it; done SHALL still pulse.
REQ-027 Unaligned address for req_size (addr mod 2^size != 0) SHALL complete without a bus cycle, with done and err=1 one cycle after grant.

Reset
REQ-028 On hresetn=0 (any time, including mid-transfer): state=IDLE; gnt=0; done=0; err=0; rdata=0; hsel=0; htrans=IDLE; haddr=0; hwrite=0; hsize=0; hwdata=0; priority pointer=0.

Configuration
REQ-029 With AHB_ARB_ROUND_ROBIN_EN defined, SHALL arbitrate round-robin: search starts at (last winner+1) mod NREQ.
REQ-030 Without AHB_ARB_ROUND_ROBIN_EN, SHALL use fixed priority, lowest index wins.

Structure
REQ-031 Shared package ahb_pkg SHALL hold the htrans/hburst/hsize/hresp constants and the FSM state enum.
REQ-032 Winner selection SHALL be sub-module ahb_rr_pick (req vector, pointer -> one-hot winner).

Verification
REQ-033 Single write, req[0], addr 0x10, size 2, wdata 0xA5A5_0001, zero wait -> NONSEQ at cycle 1, hwdata at cycle 2, done[0] at cycle 3, err=0.
REQ-034 Read back 0x10 with 2 wait states -> haddr held through the waits, done[0] at cycle 5, rdata=0xA5A5_0001.
REQ-035 req[0] and req[1] asserted continuously -> round-robin grant order 0,1,0,1; fixed-priority build grants 0 only.
REQ-036 Slave ERROR response -> done asserted with err=1 on the second ERROR cycle; the next request proceeds normally.
REQ-037 addr 0x3 with size 2 -> no NONSEQ issued; done and err=1 one cycle after gnt.
REQ-038 hresetn pulsed low during DATA -> all outputs at reset values immediately; no done pulse.
